// File: rtl/scratch_pad_streamer_if.sv
// Handshake bundle between scratch_pad_streamer, its command/stream users and its scratch pad port.
// cmd_stride exists only when SCRATCH_PAD_STREAMER_STRIDE_EN is defined.
interface scratch_pad_streamer_if #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LEN_WIDTH  = 13
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
`ifdef SCRATCH_PAD_STREAMER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] cmd_stride;
`endif
    logic                  done;

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;

    logic                  sp_rd_en;
    logic                  sp_wr_en;
    logic [ADDR_WIDTH-1:0] sp_addr;
    logic [WIDTH-1:0]      sp_d;
    logic [WIDTH-1:0]      sp_q;
    logic                  sp_valid;
    logic                  sp_full;
    logic                  sp_stall;

    modport master (
`ifdef SCRATCH_PAD_STREAMER_STRIDE_EN
        input  cmd_stride,
`endif
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready, done,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready,
        output sp_rd_en, sp_wr_en, sp_addr, sp_d, sp_stall,
        input  sp_q, sp_valid, sp_full
    );

    modport slave (
`ifdef SCRATCH_PAD_STREAMER_STRIDE_EN
        output cmd_stride,
`endif
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready, done,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready,
        input  sp_rd_en, sp_wr_en, sp_addr, sp_d, sp_stall,
        output sp_q, sp_valid, sp_full
    );
endinterface

// File: rtl/scratch_pad_streamer.sv
// Burst initiator for one scratch pad port: write bursts from an input stream, credit-limited reads to an output stream.
// Optional SCRATCH_PAD_STREAMER_STRIDE_EN: per-command address stride instead of unit increment.
module scratch_pad_streamer #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LEN_WIDTH  = 13,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    scratch_pad_streamer_if.master bus
);
    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(BUF_DEPTH);
    localparam logic [CW-1:0] BUF_FULL   = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_inc;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [WIDTH-1:0]      r_mem [BUF_DEPTH];
    logic                  r_done;

    logic                  w_accept;
    logic                  w_in_ready;
    logic                  w_write;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_set_done;
    logic [CW:0]           w_credit;

`ifdef SCRATCH_PAD_STREAMER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] r_stride;
    assign w_inc = r_stride;
`else
    assign w_inc = ADDR_WIDTH'(1);
`endif

    assign w_credit = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_push   = bus.sp_valid && (r_outstanding != '0);
    assign w_pop    = (r_count != '0) && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_in_ready   = 1'b0;
        w_write      = 1'b0;
        w_issue      = 1'b0;
        w_set_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    if (bus.cmd_len == '0) begin
                        w_set_done = 1'b1;
                    end else if (bus.cmd_write) begin
                        w_next_state = S_WRITE;
                    end else begin
                        w_next_state = S_READ;
                    end
                end
            end
            S_WRITE: begin
                w_in_ready = !bus.sp_full && (r_remaining != '0);
                w_write    = bus.in_valid && w_in_ready;
                if (w_write && (r_remaining == LEN_WIDTH'(1))) begin
                    w_next_state = S_IDLE;
                    w_set_done   = 1'b1;
                end
            end
            S_READ: begin
                // Credit counts words in flight plus words already buffered, so a return never finds the FIFO full.
                w_issue = !bus.sp_full && (r_remaining != '0) && (w_credit < CREDIT_MAX);
                if (w_issue && (r_remaining == LEN_WIDTH'(1))) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_outstanding == '0) && (r_count == '0)) begin
                    w_next_state = S_IDLE;
                    w_set_done   = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_done        <= 1'b0;
`ifdef SCRATCH_PAD_STREAMER_STRIDE_EN
            r_stride      <= '0;
`endif
        end else begin
            r_done <= w_set_done;
            if (w_accept) begin
                r_addr      <= bus.cmd_addr;
                r_remaining <= bus.cmd_len;
`ifdef SCRATCH_PAD_STREAMER_STRIDE_EN
                r_stride    <= bus.cmd_stride;
`endif
            end else if (w_write || w_issue) begin
                r_addr      <= r_addr + w_inc;
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_push);
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.sp_q;
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.done      = r_done;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.sp_rd_en  = w_issue;
    assign bus.sp_wr_en  = w_write;
    assign bus.sp_addr   = r_addr;
    assign bus.sp_d      = (r_state == S_WRITE) ? bus.in_data : '0;
    assign bus.sp_stall  = (r_count == BUF_FULL);
endmodule

// File: tb/tb_scratch_pad_streamer.sv
// Directed bench for scratch_pad_streamer: transaction-level model, per-cycle compare, literal pins per scenario.
module tb_scratch_pad_streamer;
    localparam int W  = 64;
    localparam int AW = 12;
    localparam int LW = 13;
    localparam int BD = 4;

    typedef enum int {M_IDLE, M_WRITE, M_READ, M_DRAIN} mode_t;
    typedef struct { bit wr; logic [AW-1:0] addr; int len; } cmd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scratch_pad_streamer_if #(.WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();
    scratch_pad_streamer #(.WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BUF_DEPTH(BD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    cmd_t        cmd_q[$];
    logic [W-1:0] k_wq[$];
    bit          k_out_ready, k_full_toggle, k_stray;

    logic [W-1:0] env_mem [4096];
    logic [W-1:0] ref_mem [4096];
    logic [W-1:0] rq[$];
    int           rq_due[$];
    bit           d_from_rq;

    mode_t        m_mode;
    logic [AW-1:0] m_addr;
    int           m_rem, m_out, m_done_due;
    logic [W-1:0] m_buf[$];
    logic [W-1:0] m_pend[$];

    logic [AW-1:0] wr_log[$];
    logic [W-1:0]  pop_log[$];
    int            rd_cnt, done_cnt;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        if (cmd_q.size() != 0) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = cmd_q[0].wr;
            bus.cmd_addr  = cmd_q[0].addr;
            bus.cmd_len   = LW'(cmd_q[0].len);
        end else begin
            bus.cmd_valid = 1'b0;
            bus.cmd_write = 1'b0;
            bus.cmd_addr  = '0;
            bus.cmd_len   = '0;
        end
`ifdef SCRATCH_PAD_STREAMER_STRIDE_EN
        bus.cmd_stride = AW'(1);
`endif
        bus.in_valid  = (k_wq.size() != 0);
        bus.in_data   = (k_wq.size() != 0) ? k_wq[0] : '0;
        bus.out_ready = k_out_ready;
        bus.sp_full   = k_full_toggle && (cyc % 2 == 1);
        d_from_rq = 1'b0;
        if (rq.size() != 0 && rq_due[0] <= cyc) begin
            bus.sp_valid = 1'b1;
            bus.sp_q     = rq[0];
            d_from_rq    = 1'b1;
        end else if (k_stray) begin
            bus.sp_valid = 1'b1;
            bus.sp_q     = 64'hBAD0_BAD0_BAD0_BAD0;
        end else begin
            bus.sp_valid = 1'b0;
            bus.sp_q     = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run_idle(input string name, input int budget);
        int n = 0;
        while ((cmd_q.size() != 0 || m_mode != M_IDLE || m_done_due >= cyc) && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s timeout after %0d cycles, required completion", name, n);
        end
    endtask

    // Compare process: model outputs from the burst rules, then advance model and scratch pad environment.
    always @(negedge clk) begin : compare
        bit acc, e_inr, e_wr, e_rd, ret, pop;
        if (!rst) begin
            chk("rst_cmd_ready", bus.cmd_ready, 1);
            chk("rst_done", bus.done, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_sp_rd_en", bus.sp_rd_en, 0);
            chk("rst_sp_wr_en", bus.sp_wr_en, 0);
            chk("rst_sp_stall", bus.sp_stall, 0);
            chk("rst_sp_addr", bus.sp_addr, 0);
            chk("rst_sp_d", bus.sp_d, 0);
            m_mode = M_IDLE;
            m_addr = '0;
            m_rem = 0;
            m_out = 0;
            m_done_due = -1;
            m_buf.delete();
            m_pend.delete();
        end else begin
            acc   = bus.cmd_valid && (m_mode == M_IDLE);
            e_inr = (m_mode == M_WRITE) && !bus.sp_full && (m_rem != 0);
            e_wr  = e_inr && bus.in_valid;
            e_rd  = (m_mode == M_READ) && !bus.sp_full && (m_rem != 0) && (m_out + m_buf.size() < BD);
            ret   = bus.sp_valid && (m_out != 0);
            pop   = (m_buf.size() != 0) && bus.out_ready;

            chk("cmd_ready", bus.cmd_ready, m_mode == M_IDLE);
            chk("done", bus.done, m_done_due == cyc);
            chk("in_ready", bus.in_ready, e_inr);
            chk("sp_wr_en", bus.sp_wr_en, e_wr);
            chk("sp_rd_en", bus.sp_rd_en, e_rd);
            chk("out_valid", bus.out_valid, m_buf.size() != 0);
            chk("sp_stall", bus.sp_stall, m_buf.size() == BD);
            if (m_buf.size() != 0) chk("out_data", bus.out_data, m_buf[0]);
            if (e_wr || e_rd) chk("sp_addr", bus.sp_addr, m_addr);
            if (e_wr) chk("sp_d", bus.sp_d, bus.in_data);

            if (m_mode == M_DRAIN && m_out == 0 && m_buf.size() == 0) begin
                m_mode = M_IDLE;
                m_done_due = cyc + 1;
            end
            if (acc) begin
                void'(cmd_q.pop_front());
                m_addr = bus.cmd_addr;
                m_rem  = int'(bus.cmd_len);
                if (m_rem == 0) m_done_due = cyc + 1;
                else m_mode = bus.cmd_write ? M_WRITE : M_READ;
            end
            if (pop) void'(m_buf.pop_front());
            if (ret) begin
                m_buf.push_back(m_pend.pop_front());
                m_out--;
            end
            if (e_wr) begin
                ref_mem[m_addr] = bus.in_data;
                void'(k_wq.pop_front());
                m_addr++;
                m_rem--;
                if (m_rem == 0) begin
                    m_mode = M_IDLE;
                    m_done_due = cyc + 1;
                end
            end
            if (e_rd) begin
                m_pend.push_back(ref_mem[m_addr]);
                m_out++;
                m_addr++;
                m_rem--;
                if (m_rem == 0) m_mode = M_DRAIN;
            end
        end

        if (bus.sp_wr_en === 1'b1) begin
            env_mem[bus.sp_addr] = bus.sp_d;
            wr_log.push_back(bus.sp_addr);
        end
        if (bus.sp_rd_en === 1'b1) begin
            rq.push_back(env_mem[bus.sp_addr]);
            rq_due.push_back(cyc + 3);
            rd_cnt++;
        end
        if (d_from_rq) begin
            void'(rq.pop_front());
            void'(rq_due.pop_front());
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) pop_log.push_back(bus.out_data);
        if (bus.done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        k_out_ready = 1'b0;
        k_full_toggle = 1'b0;
        k_stray = 1'b0;
        rd_cnt = 0;
        done_cnt = 0;
        m_mode = M_IDLE;
        m_done_due = -1;
        rst = 1'b0;
        drive();
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Write burst 0x010..0x013
        wr_log.delete();
        done_cnt = 0;
        for (int i = 0; i < 4; i++) k_wq.push_back(64'hA0 + 64'(i));
        cmd_q.push_back('{1'b1, 12'h010, 4});
        run_idle("write4", 50);
        chk("w4_count", 64'(wr_log.size()), 4);
        for (int i = 0; i < 4; i++) chk("w4_addr", 64'(wr_log[i]), 64'h010 + 64'(i));
        chk("w4_done_cnt", 64'(done_cnt), 1);

        // Read burst back, always-ready consumer
        pop_log.delete();
        done_cnt = 0;
        k_out_ready = 1'b1;
        cmd_q.push_back('{1'b0, 12'h010, 4});
        run_idle("read4", 50);
        chk("r4_count", 64'(pop_log.size()), 4);
        for (int i = 0; i < 4; i++) chk("r4_data", pop_log[i], 64'hA0 + 64'(i));
        chk("r4_done_cnt", 64'(done_cnt), 1);

        // Credit limit: back-to-back write then read with a stalled consumer
        k_out_ready = 1'b0;
        rd_cnt = 0;
        pop_log.delete();
        for (int i = 0; i < 10; i++) k_wq.push_back(64'h100 + 64'(i));
        cmd_q.push_back('{1'b1, 12'h100, 10});
        cmd_q.push_back('{1'b0, 12'h100, 10});
        repeat (40) tick();
        chk("credit_reads", 64'(rd_cnt), 4);
        chk("credit_stall", bus.sp_stall, 1);
        chk("credit_out_valid", bus.out_valid, 1);
        k_out_ready = 1'b1;
        run_idle("credit_read10", 200);
        chk("r10_count", 64'(pop_log.size()), 10);
        for (int i = 0; i < 10; i++) chk("r10_data", pop_log[i], 64'h100 + 64'(i));
        chk("r10_reads", 64'(rd_cnt), 10);

        // Address wrap at top of the scratch pad
        wr_log.delete();
        for (int i = 0; i < 3; i++) k_wq.push_back(64'hB0 + 64'(i));
        cmd_q.push_back('{1'b1, 12'hFFE, 3});
        run_idle("wrap3", 50);
        chk("wrap_count", 64'(wr_log.size()), 3);
        chk("wrap_a0", 64'(wr_log[0]), 64'hFFE);
        chk("wrap_a1", 64'(wr_log[1]), 64'hFFF);
        chk("wrap_a2", 64'(wr_log[2]), 64'h000);

        // Zero-length commands plus a stray return while idle
        wr_log.delete();
        rd_cnt = 0;
        done_cnt = 0;
        pop_log.delete();
        cmd_q.push_back('{1'b0, 12'h123, 0});
        cmd_q.push_back('{1'b1, 12'h050, 0});
        run_idle("zero_len", 20);
        k_stray = 1'b1;
        tick();
        k_stray = 1'b0;
        repeat (3) tick();
        chk("zero_reads", 64'(rd_cnt), 0);
        chk("zero_writes", 64'(wr_log.size()), 0);
        chk("zero_done_cnt", 64'(done_cnt), 2);
        chk("stray_idle_pops", 64'(pop_log.size()), 0);

        // Read under a toggling sp_full
        pop_log.delete();
        k_full_toggle = 1'b1;
        cmd_q.push_back('{1'b0, 12'h100, 6});
        run_idle("full_read6", 100);
        k_full_toggle = 1'b0;
        chk("full_count", 64'(pop_log.size()), 6);
        for (int i = 0; i < 6; i++) chk("full_data", pop_log[i], 64'h100 + 64'(i));

        // Reset mid-burst, late returns, then normal traffic
        cmd_q.push_back('{1'b0, 12'h100, 8});
        repeat (5) tick();
        rst = 1'b0;
        cmd_q.delete();
        k_wq.delete();
        tick();
        rst = 1'b1;
        pop_log.delete();
        repeat (4) tick();
        k_stray = 1'b1;
        tick();
        k_stray = 1'b0;
        repeat (3) tick();
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_pops", 64'(pop_log.size()), 0);
        k_wq.push_back(64'hC0);
        k_wq.push_back(64'hC1);
        cmd_q.push_back('{1'b1, 12'h200, 2});
        cmd_q.push_back('{1'b0, 12'h200, 2});
        run_idle("post_rst", 60);
        chk("post_rst_count", 64'(pop_log.size()), 2);
        chk("post_rst_d0", pop_log[0], 64'hC0);
        chk("post_rst_d1", pop_log[1], 64'hC1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/scratch_pad_streamer.md
Name: scratch_pad_streamer

Overview:
- Initiator for one port of the multi-port scratch pad.
- Converts a {base, length, direction} command into a burst of single-word accesses:
  - Write bursts drain a ready/valid input stream into consecutive addresses.
  - Read bursts issue credit-limited reads and return the data in order on a ready/valid output stream.
- One instance per scratch pad port. Sits between a compute/DMA engine and the scratch pad.

Parameters:
- WIDTH, 64, data word width; matches the scratch pad WIDTH.
- ADDR_WIDTH, 12, word address width; matches the scratch pad ADDR_WIDTH (4096 words).
- LEN_WIDTH, 13, burst length width; lengths 0..2^LEN_WIDTH-1 words.
- BUF_DEPTH, 4, read return buffer depth; also the maximum outstanding-plus-buffered read credit (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  streamer idle, command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_WIDTH  base word address.
- cmd_len  in  LEN_WIDTH  number of words.
- done  out  1  one-cycle pulse when a burst completes.
- in_valid  in  1  write data valid.
- in_ready  out  1  write data consumed this cycle.
- in_data  in  WIDTH  write data.
- out_valid  out  1  read data valid.
- out_ready  in  1  consumer accepts read data.
- out_data  out  WIDTH  read data.
- sp_rd_en  out  1  read request to scratch pad port.
- sp_wr_en  out  1  write request to scratch pad port.
- sp_addr  out  ADDR_WIDTH  request address.
- sp_d  out  WIDTH  write data to scratch pad.
- sp_q  in  WIDTH  read data from scratch pad.
- sp_valid  in  1  sp_q valid; returns are in request order.
- sp_full  in  1  port cannot accept a request this cycle.
- sp_stall  out  1  back-pressure to scratch pad read return.

Behaviour:
- Reset (rst low, async):
  - State is IDLE; addr, remaining, outstanding and buffer pointers are 0.
  - Outputs: cmd_ready=1, done=0, in_ready=0, out_valid=0, sp_rd_en=0, sp_wr_en=0, sp_stall=0.
  - sp_addr and sp_d are 0.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1. On accept, latch addr=cmd_addr and remaining=cmd_len.
  - If cmd_len==0: go to IDLE, done=1 next cycle, no scratch pad access.
  - Otherwise go to WRITE or READ per cmd_write.
- WRITE:
  - in_ready = !sp_full && remaining!=0.
  - sp_wr_en = in_valid && in_ready. sp_d = in_data and sp_addr = addr, both combinational.
  - On each write: addr+1 (mod 2^ADDR_WIDTH, wraps 4095->0), remaining-1.
  - The last write goes to IDLE with done=1 in the following cycle.
- READ:
  - credit = outstanding + buffer occupancy.
  - sp_rd_en = !sp_full && remaining!=0 && credit<BUF_DEPTH. sp_addr = addr.
  - On issue: outstanding+1, addr+1 (wrapping), remaining-1.
  - Once remaining reaches 0, go to DRAIN.
- DRAIN:
  - No new requests.
  - When outstanding==0 and the buffer is empty, go to IDLE; done=1 for one cycle.
- Return path (READ and DRAIN):
  - sp_valid && outstanding!=0 pushes sp_q into the FIFO and decrements outstanding.
  - sp_valid with outstanding==0 is ignored.
  - out_valid = FIFO not empty; out_data = FIFO head; pop on out_valid&&out_ready.
  - Issue, return and pop may coincide in one cycle; counters net correctly.
  - sp_stall = (occupancy==BUF_DEPTH); the credit rule guarantees no push into a full FIFO.
- Back-to-back bursts: a new command may be accepted in the cycle done is asserted (IDLE).
- Reset mid-burst: the burst is abandoned. Late sp_valid returns are ignored because outstanding==0.

Optional Feature:
- Macro SCRATCH_PAD_STREAMER_STRIDE_EN.
- When defined:
  - Adds input cmd_stride [ADDR_WIDTH-1:0], latched on command accept.
  - The address advances by the stride, modulo 2^ADDR_WIDTH, instead of by 1.
  - A stride of 0 repeatedly accesses the base address.
- When undefined: no cmd_stride port; the increment is fixed at 1.

Test Plan:
- Write burst: addr=0x010, len=4, in_data 0xA0..0xA3, sp_full=0 -> sp_wr_en on 4 consecutive cycles, sp_addr 0x010..0x013, done pulses once afterwards.
- Read burst: addr=0x010, len=4, scratch pad latency 3 cycles, out_ready=1 -> out_data 0xA0..0xA3 in order, done pulses after the last pop.
- Credit limit: read len=10, out_ready=0 -> exactly BUF_DEPTH=4 reads issued, sp_stall=1 once 4 words are buffered. Raising out_ready completes all 10 words in order.
- Wrap and zero length: write addr=0xFFE, len=3 -> addresses 0xFFE, 0xFFF, 0x000. A len=0 command -> done one cycle after accept, no sp_rd_en or sp_wr_en.
- sp_full and reset: sp_full toggling every other cycle during a read len=6 -> no request issued while sp_full=1, 6 words returned. Assert rst mid-burst -> outputs return to reset values, stray sp_valid ignored, next command runs normally.
